pc_sequencer: RTL and testbench

//  Fetch/execute sequencer for the program counter. Drives the counter's active-low load (ld)
//  and load value (in) every cycle; the counter self-increments whenever ld=1.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the minicpu program counter: drives the counter's
// load/increment control and handles fetch handshake, branch, interrupt and halt.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// state | meaning
// IDLE  | waiting for start, PC held
// FETCH | instruction request outstanding, PC held until mem_ack
// EXEC  | one-cycle execute strobe, PC redirect resolved here
// HALT  | stopped, only reset leaves
module pc_sequencer #(
  parameter logic [`DATA_WIDTH-1:0] IRQ_VECTOR     = `DATA_WIDTH'(4),
  parameter bit                     START_ON_RESET = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [`DATA_WIDTH-1:0] pc,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic                   ir_ld,
  output logic                   exec_en,
  input  logic                   br_taken,
  input  logic [`DATA_WIDTH-1:0] br_target,
  input  logic                   reti_req,
  input  logic                   halt_req,
  input  logic                   irq,
  output logic                   irq_ack,
  output logic [`DATA_WIDTH-1:0] pc_in,
  output logic                   pc_ld_n,
  output logic [`DATA_WIDTH-1:0] epc,
  output logic                   ie,
  output logic                   halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t state;

  // Outputs decode from state so an async reset drops mem_req in the same cycle.
  always_comb begin
    pc_in   = pc;
    pc_ld_n = 1'b0;
    mem_req = 1'b0;
    ir_ld   = 1'b0;
    exec_en = 1'b0;
    irq_ack = 1'b0;
    halted  = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld   = 1'b1;
          pc_ld_n = 1'b1;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        if (halt_req) begin
          pc_in = pc;
        end else if (reti_req) begin
          pc_in = epc;
        end else if (irq && ie) begin
          pc_in   = IRQ_VECTOR;
          irq_ack = 1'b1;
        end else if (br_taken) begin
          pc_in = br_target;
        end
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      epc   <= '0;
      ie    <= 1'b1;
    end else begin
      case (state)
        IDLE:  if (start || START_ON_RESET) state <= FETCH;
        FETCH: if (mem_ack) state <= EXEC;
        EXEC: begin
          if (halt_req) begin
            state <= HALT;
          end else begin
            state <= FETCH;
            if (reti_req) begin
              ie <= 1'b1;
            end else if (irq && ie) begin
              ie  <= 1'b0;
              // Return lands where this instruction would have gone.
              epc <= br_taken ? br_target : pc;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural program counter attached.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pc;
  logic       mem_req;
  logic       mem_ack;
  logic       ir_ld;
  logic       exec_en;
  logic       br_taken;
  logic [7:0] br_target;
  logic       reti_req;
  logic       halt_req;
  logic       irq;
  logic       irq_ack;
  logic [7:0] pc_in;
  logic       pc_ld_n;
  logic [7:0] epc;
  logic       ie;
  logic       halted;

  int tests  = 0;
  int failed = 0;
  int n_ir   = 0;
  int n_ex   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.IRQ_VECTOR(8'h04), .START_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .mem_req(mem_req), .mem_ack(mem_ack), .ir_ld(ir_ld), .exec_en(exec_en),
    .br_taken(br_taken), .br_target(br_target), .reti_req(reti_req),
    .halt_req(halt_req), .irq(irq), .irq_ack(irq_ack), .pc_in(pc_in),
    .pc_ld_n(pc_ld_n), .epc(epc), .ie(ie), .halted(halted)
  );

  // External program counter: load when pc_ld_n=0, otherwise increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= 8'h00;
    else if (!pc_ld_n) pc <= pc_in;
    else               pc <= pc + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (ir_ld)   n_ir <= n_ir + 1;
    if (exec_en) n_ex <= n_ex + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From a FETCH slot: wait cycles without ack, then ack; returns in the EXEC slot.
  task automatic fetch(input int waits, input logic [7:0] exp_pc);
    mem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("wait_mem_req", mem_req, 1);
      chk("wait_ir_ld", ir_ld, 0);
      chk("wait_pc_hold", pc, exp_pc);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("ack_mem_req", mem_req, 1);
    chk("ack_ir_ld", ir_ld, 1);
    chk("ack_pc_ld_n", pc_ld_n, 1);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("exec_en", exec_en, 1);
    chk("exec_mem_req", mem_req, 0);
    chk("exec_pc", pc, exp_pc + 8'h01);
  endtask

  task automatic clear_exec;
    br_taken  = 1'b0;
    br_target = 8'h00;
    reti_req  = 1'b0;
    halt_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; irq = 1'b0;
    clear_exec();
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_ld_n", pc_ld_n, 0);
    chk("rst_pc_in", pc_in, pc);
    chk("rst_ie", ie, 1);
    chk("rst_epc", epc, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_pc", pc, 0);
      chk("idle_mem_req", mem_req, 0);
      chk("idle_pc_ld_n", pc_ld_n, 0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    n_ir = 0; n_ex = 0;
    fetch(3, 8'h00);
    tick();
    fetch(0, 8'h01);
    tick();
    fetch(0, 8'h02);
    tick();
    chk("pc_after_3", pc, 8'h03);
    chk("ir_ld_count", n_ir, 3);
    chk("exec_count", n_ex, 3);

    fetch(1, 8'h03);
    tick();
    fetch(0, 8'h04);
    br_taken = 1'b1; br_target = 8'h20;
    #1;
    chk("br_pc_ld_n", pc_ld_n, 0);
    chk("br_pc_in", pc_in, 8'h20);
    tick();
    clear_exec();
    chk("br_mem_req", mem_req, 1);
    chk("br_pc", pc, 8'h20);

    irq = 1'b1;
    fetch(0, 8'h20);
    br_taken = 1'b1; br_target = 8'h30;
    #1;
    chk("irq_ack_pulse", irq_ack, 1);
    chk("irq_pc_in", pc_in, 8'h04);
    chk("irq_pc_ld_n", pc_ld_n, 0);
    tick();
    clear_exec();
    chk("irq_pc", pc, 8'h04);
    chk("irq_epc", epc, 8'h30);
    chk("irq_ie", ie, 0);
    chk("irq_ack_drop", irq_ack, 0);

    fetch(0, 8'h04);
    chk("masked_irq_ack", irq_ack, 0);
    tick();
    fetch(0, 8'h05);
    reti_req = 1'b1;
    #1;
    chk("reti_pc_in", pc_in, 8'h30);
    chk("reti_irq_ack", irq_ack, 0);
    tick();
    clear_exec();
    chk("reti_pc", pc, 8'h30);
    chk("reti_ie", ie, 1);

    fetch(0, 8'h30);
    chk("pending_irq_ack", irq_ack, 1);
    chk("pending_pc_in", pc_in, 8'h04);
    tick();
    irq = 1'b0;
    chk("pending_epc", epc, 8'h31);
    chk("pending_pc", pc, 8'h04);

    fetch(0, 8'h04);
    halt_req = 1'b1; br_taken = 1'b1; br_target = 8'h55;
    #1;
    chk("halt_pc_ld_n", pc_ld_n, 0);
    chk("halt_pc_in", pc_in, 8'h05);
    tick();
    clear_exec();
    chk("halted", halted, 1);
    start = 1'b1; irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_mem_req", mem_req, 0);
      chk("halt_pc", pc, 8'h05);
    end
    start = 1'b0; irq = 1'b0;

    reset = 1'b1;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_ie", ie, 1);
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_mem_req", mem_req, 1);
    tick();
    chk("fetch_wait_mem_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_ie", ie, 1);
    chk("abort_epc", epc, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_idle_mem_req", mem_req, 0);
    chk("abort_idle_pc_ld_n", pc_ld_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
